// File: rtl/cell_stim_chk4.sv
// Stimulus driver and truth-table checker for 4-input combinational cells.
// Optional per-vector failure map output enabled by CELL_STIM_CHK4_FAILMAP_EN.
module cell_stim_chk4 #(
    parameter logic [15:0] TRUTH      = 16'h007F,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        Y_IN,
    output logic        A0,
    output logic        A1,
    output logic        A2,
    output logic        B,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [4:0]  ERR_CNT
`ifdef CELL_STIM_CHK4_FAILMAP_EN
    ,
    output logic [15:0] FAIL_MAP
`endif
);

    // state    | meaning
    // S_IDLE   | waiting for START
    // S_APPLY  | vector idx driven, settle counter loaded
    // S_WAIT   | counting down SETTLE_CYC cycles
    // S_SAMPLE | compare Y_IN against TRUTH[idx]
    // S_DONE   | one-cycle end-of-run marker
    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] settle_cnt;
    logic [3:0] stim;
    logic       mismatch;
    logic [4:0] err_next;

    assign {B, A2, A1, A0} = stim;
    assign mismatch = (Y_IN != TRUTH[idx]);
    // PASS must see the last sample's contribution, so it is derived from the next count.
    assign err_next = ERR_CNT + {4'd0, mismatch};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            stim       <= 4'd0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= 5'd0;
`ifdef CELL_STIM_CHK4_FAILMAP_EN
            FAIL_MAP   <= 16'd0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_APPLY;
                        idx     <= 4'd0;
                        stim    <= 4'd0;
                        BUSY    <= 1'b1;
                        ERR_CNT <= 5'd0;
                        PASS    <= 1'b0;
`ifdef CELL_STIM_CHK4_FAILMAP_EN
                        FAIL_MAP <= 16'd0;
`endif
                    end
                end
                S_APPLY: begin
                    settle_cnt <= SETTLE;
                    state      <= (SETTLE != 4'd0) ? S_WAIT : S_SAMPLE;
                end
                S_WAIT: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    ERR_CNT <= err_next;
`ifdef CELL_STIM_CHK4_FAILMAP_EN
                    if (mismatch) begin
                        FAIL_MAP[idx] <= 1'b1;
                    end
`endif
                    if (idx == 4'd15) begin
                        state <= S_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (err_next == 5'd0);
                    end else begin
                        idx   <= idx + 4'd1;
                        stim  <= idx + 4'd1;
                        state <= S_APPLY;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_stim_chk4.sv
// Directed bench for cell_stim_chk4: four instances at settle 2/0/1/3 with ideal,
// stuck and delayed aoi31 models on Y_IN.
module tb_cell_stim_chk4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst   = 4'hF;
    logic [3:0] start = 4'h0;
    logic [3:0] a0, a1, a2, b, busy, done, pass;
    logic [3:0] y_in, ideal;
    logic [3:0] d1 = 4'hF, d2 = 4'hF, d3 = 4'hF;
    logic [4:0] err [4];
    logic [1:0] ymode [4];
`ifdef CELL_STIM_CHK4_FAILMAP_EN
    logic [15:0] fmap [4];
`endif

    int n_chk = 0;
    int n_err = 0;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        cell_stim_chk4 #(
            .TRUTH     (16'h007F),
            .SETTLE_CYC(k == 0 ? 2 : (k == 1 ? 0 : (k == 2 ? 1 : 3)))
        ) u_dut (
            .CLK    (clk),
            .RST    (rst[k]),
            .START  (start[k]),
            .Y_IN   (y_in[k]),
            .A0     (a0[k]),
            .A1     (a1[k]),
            .A2     (a2[k]),
            .B      (b[k]),
            .BUSY   (busy[k]),
            .DONE   (done[k]),
            .PASS   (pass[k]),
            .ERR_CNT(err[k])
`ifdef CELL_STIM_CHK4_FAILMAP_EN
            ,
            .FAIL_MAP(fmap[k])
`endif
        );
        assign ideal[k] = ~((a0[k] & a1[k] & a2[k]) | b[k]);
    end

    // three-cycle delayed copy of the ideal cell output
    always @(posedge clk) begin
        d1 <= ideal;
        d2 <= d1;
        d3 <= d2;
    end

    always_comb begin
        y_in = ideal;
        for (int k = 0; k < 4; k++) begin
            case (ymode[k])
                2'd1:    y_in[k] = 1'b0;
                2'd2:    y_in[k] = 1'b1;
                2'd3:    y_in[k] = d3[k];
                default: y_in[k] = ideal[k];
            endcase
        end
    end

    function automatic logic [3:0] stim_of(input int k);
        return {b[k], a2[k], a1[k], a0[k]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int k, input string tag, input int exp_cyc,
                       input logic [4:0] exp_err, input logic exp_pass,
                       input logic [15:0] exp_map, input int repulse_at);
        int         cyc;
        int         walk_bad;
        bit         repulsed;
        logic [3:0] prev;
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        cyc      = 1;
        walk_bad = 0;
        repulsed = 1'b0;
        prev     = stim_of(k);
        chk({tag, " busy_start"}, 32'(busy[k]), 32'd1);
        chk({tag, " vec0"}, 32'(prev), 32'd0);
        while (!done[k] && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start[k] = 1'b0;
            if (stim_of(k) != prev) begin
                if (stim_of(k) != prev + 4'd1) walk_bad++;
                prev = stim_of(k);
            end
            if (!repulsed && repulse_at >= 0 && int'(prev) == repulse_at) begin
                start[k] = 1'b1;
                repulsed = 1'b1;
            end
        end
        chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, " err_cnt"}, 32'(err[k]), 32'(exp_err));
        chk({tag, " pass"}, 32'(pass[k]), 32'(exp_pass));
        chk({tag, " busy_done"}, 32'(busy[k]), 32'd0);
        chk({tag, " walk"}, 32'(walk_bad), 32'd0);
        chk({tag, " last_vec"}, 32'(stim_of(k)), 32'd15);
`ifdef CELL_STIM_CHK4_FAILMAP_EN
        chk({tag, " fail_map"}, 32'(fmap[k]), 32'(exp_map));
`endif
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, 32'(done[k]), 32'd0);
        chk({tag, " pass_hold"}, 32'(pass[k]), 32'(exp_pass));
        chk({tag, " vec_hold"}, 32'(stim_of(k)), 32'd15);
    endtask

    initial begin
        int dn;
        int i;
        ymode[0] = 2'd0;
        ymode[1] = 2'd0;
        ymode[2] = 2'd3;
        ymode[3] = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst vec", 32'(stim_of(0)), 32'd0);
        chk("rst busy", 32'(busy[0]), 32'd0);
        chk("rst done", 32'(done[0]), 32'd0);
        chk("rst pass", 32'(pass[0]), 32'd0);
        chk("rst err", 32'(err[0]), 32'd0);
        @(negedge clk);
        rst = 4'h0;

        run(0, "ideal", 65, 5'd0, 1'b1, 16'h0000, -1);
        ymode[0] = 2'd1;
        run(0, "stuck0", 65, 5'd7, 1'b0, 16'h007F, -1);
        ymode[0] = 2'd2;
        run(0, "stuck1", 65, 5'd9, 1'b0, 16'hFF80, -1);
        ymode[0] = 2'd0;
        run(1, "settle0", 33, 5'd0, 1'b1, 16'h0000, -1);
        run(2, "dly_s1", 49, 5'd1, 1'b0, 16'h0080, -1);
        run(3, "dly_s3", 81, 5'd0, 1'b1, 16'h0000, -1);
        run(0, "repulse", 65, 5'd0, 1'b1, 16'h0000, 5);

        // reset in the middle of a failing run
        ymode[0] = 2'd1;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        i = 0;
        while (stim_of(0) != 4'd9 && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("mid vec9", 32'(stim_of(0)), 32'd9);
        chk("mid err", 32'(err[0]), 32'd7);
        rst[0] = 1'b1;
        #1;
        chk("abort vec", 32'(stim_of(0)), 32'd0);
        chk("abort busy", 32'(busy[0]), 32'd0);
        chk("abort pass", 32'(pass[0]), 32'd0);
        chk("abort err", 32'(err[0]), 32'd0);
        chk("abort done", 32'(done[0]), 32'd0);
        @(negedge clk);
        rst[0]   = 1'b0;
        ymode[0] = 2'd0;
        dn = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done[0]) dn++;
        end
        chk("abort no_done", 32'(dn), 32'd0);
        chk("abort idle", 32'(busy[0]), 32'd0);
        run(0, "post_rst", 65, 5'd0, 1'b1, 16'h0000, -1);

        // START held high: restart on the edge after DONE returns to IDLE
        @(negedge clk);
        start[0] = 1'b1;
        i = 0;
        do begin
            @(posedge clk);
            #1;
            i++;
        end while (!done[0] && i < 200);
        chk("held done", 32'(done[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("held idle", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("held restart", 32'(busy[0]), 32'd1);
        chk("held restart vec", 32'(stim_of(0)), 32'd0);
        start[0] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
